// File: rtl/tetris_pkg.sv
// Shared encodings for the Tetris move path: command codes, PS/2 scan codes,
// arbiter states and the keyboard make-code decoder.
package tetris_pkg;

    localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

    typedef enum logic [2:0] {
        OP_LEFT    = 3'd0,
        OP_RIGHT   = 3'd1,
        OP_DOWN    = 3'd2,
        OP_ROTATE  = 3'd3,
        OP_GRAVITY = 3'd4
    } cmd_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } arb_state_e;

    localparam logic [7:0] SC_BREAK       = 8'hF0;
    localparam logic [7:0] SC_EXT         = 8'hE0;
    localparam logic [7:0] SC_KEY_A       = 8'h1C;
    localparam logic [7:0] SC_KEY_D       = 8'h23;
    localparam logic [7:0] SC_KEY_S       = 8'h1B;
    localparam logic [7:0] SC_KEY_W       = 8'h1D;
    localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
    localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
    localparam logic [7:0] SC_ARROW_UP    = 8'h75;

    typedef struct packed {
        logic    hit;
        cmd_op_e op;
    } key_dec_t;

    function automatic key_dec_t decode_make(input logic [7:0] code, input logic ext);
        key_dec_t d;
        d.hit = 1'b1;
        d.op  = OP_LEFT;
        if (ext) begin
            case (code)
                SC_ARROW_LEFT:  d.op = OP_LEFT;
                SC_ARROW_RIGHT: d.op = OP_RIGHT;
                SC_ARROW_DOWN:  d.op = OP_DOWN;
                SC_ARROW_UP:    d.op = OP_ROTATE;
                default:        d.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_KEY_A: d.op = OP_LEFT;
                SC_KEY_D: d.op = OP_RIGHT;
                SC_KEY_S: d.op = OP_DOWN;
                SC_KEY_W: d.op = OP_ROTATE;
                default:  d.hit = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Small synchronous FIFO of 3-bit move commands with occupancy count and flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module move_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [2:0]               din,
    output logic [2:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/move_scheduler.sv
// Turns PS/2 key bytes and gravity ticks into a serialized stream of board moves,
// buffering keys in a FIFO and giving gravity priority at the arbiter.
module move_scheduler
    import tetris_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                          CLOCK_50,
    input  logic                          Resetn,
    input  logic [7:0]                    scan_data,
    input  logic                          scan_valid,
    input  logic                          game_active,
    input  logic                          gravity_tick,
    input  logic                          cmd_ack,
    output logic                          cmd_valid,
    output logic [2:0]                    cmd_op,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    arb_state_e state;
    arb_state_e state_nxt;
    cmd_op_e    cmd_op_q;
    logic       break_pend;
    logic       ext_pend;
    logic       grav_pend;
    key_dec_t   key_dec;
    logic       key_push;
    logic       take_grav;
    logic       take_key;
    logic [2:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;

    // Decoder state keeps tracking even outside gameplay so a prefix byte is never lost.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
        end else if (scan_valid) begin
            if (break_pend) begin
                break_pend <= 1'b0;
                ext_pend   <= 1'b0;
            end else if (scan_data == SC_BREAK) begin
                break_pend <= 1'b1;
            end else if (scan_data == SC_EXT) begin
                ext_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
            end
        end
    end

    assign key_dec  = decode_make(scan_data, ext_pend);
    assign key_push = scan_valid && !break_pend && key_dec.hit && game_active;

    move_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (Resetn),
        .flush (!game_active),
        .push  (key_push),
        .pop   (take_key),
        .din   (key_dec.op),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A tick arriving in the same cycle gravity is issued re-arms the pending flag.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            grav_pend <= 1'b0;
        end else if (!game_active) begin
            grav_pend <= 1'b0;
        end else if (gravity_tick) begin
            grav_pend <= 1'b1;
        end else if (take_grav) begin
            grav_pend <= 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            overflow <= 1'b0;
        end else if (!game_active) begin
            overflow <= 1'b0;
        end else if (key_push && fifo_full && !take_key) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!game_active) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (take_grav || take_key) state_nxt = ST_ISSUE;
                ST_ISSUE: if (cmd_ack) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_valid = (state == ST_ISSUE);
        take_grav = 1'b0;
        take_key  = 1'b0;
        if (state == ST_IDLE && game_active) begin
            take_grav = grav_pend;
            take_key  = !grav_pend && !fifo_empty;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            cmd_op_q <= OP_LEFT;
        end else if (take_grav) begin
            cmd_op_q <= OP_GRAVITY;
        end else if (take_key) begin
            cmd_op_q <= cmd_op_e'(fifo_dout);
        end
    end

    assign cmd_op = cmd_op_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: directed scenarios plus a randomized
// run compared against a queue-based behavioural model.
module tb_move_scheduler;

    localparam int DEPTH = 4;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn;
    logic [7:0] scan_data;
    logic       scan_valid;
    logic       game_active;
    logic       gravity_tick;
    logic       cmd_ack;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [2:0] fifo_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    move_scheduler #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .Resetn       (Resetn),
        .scan_data    (scan_data),
        .scan_valid   (scan_valid),
        .game_active  (game_active),
        .gravity_tick (gravity_tick),
        .cmd_ack      (cmd_ack),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        scan_data  = b;
        scan_valid = 1'b1;
        tick();
        scan_valid = 1'b0;
    endtask

    task automatic test_reset();
        Resetn = 1'b0; scan_data = '0; scan_valid = 1'b0; game_active = 1'b0;
        gravity_tick = 1'b0; cmd_ack = 1'b0;
        #5;
        checks++;
        if ({cmd_valid, cmd_op, fifo_count, overflow} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got valid=%b op=%0d cnt=%0d ovf=%b want all 0",
                     cmd_valid, cmd_op, fifo_count, overflow);
        end
        tick();
        Resetn = 1'b1;
        game_active = 1'b1;
        tick();
    endtask

    task automatic test_single_key();
        send(8'h1C);
        checks++;
        if (cmd_valid !== 1'b0 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL single_n1 got valid=%b cnt=%0d want 0/1", cmd_valid, fifo_count);
        end
        tick();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 3'd0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL single_n2 got valid=%b op=%0d cnt=%0d want 1/0/0", cmd_valid, cmd_op, fifo_count);
        end
        cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_ack got valid=%b want 0", cmd_valid);
        end
    endtask

    task automatic test_break_ext();
        logic [7:0] seq [7];
        seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hF0, 8'h1D};
        foreach (seq[i]) send(seq[i]);
        tick();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 3'd3 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL break_ext got valid=%b op=%0d cnt=%0d want 1/3/0", cmd_valid, cmd_op, fifo_count);
        end
        cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
        tick(); tick();
        checks++;
        if (cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL break_ext_single got valid=%b cnt=%0d want 0/0", cmd_valid, fifo_count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) send(8'h23);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 3'd1 || fifo_count !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow got valid=%b op=%0d cnt=%0d ovf=%b want 1/1/4/1",
                     cmd_valid, cmd_op, fifo_count, overflow);
        end
        game_active = 1'b0; tick(); game_active = 1'b1;
        checks++;
        if (cmd_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got valid=%b cnt=%0d ovf=%b want 0/0/0", cmd_valid, fifo_count, overflow);
        end
    endtask

    task automatic test_gravity();
        gravity_tick = 1'b1;
        send(8'h1B);
        gravity_tick = 1'b0;
        tick();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 3'd4 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL grav_first got valid=%b op=%0d cnt=%0d want 1/4/1", cmd_valid, cmd_op, fifo_count);
        end
        cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL grav_gap got valid=%b want 0", cmd_valid);
        end
        tick();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 3'd2) begin
            errors++;
            $display("FAIL grav_then_down got valid=%b op=%0d want 1/2", cmd_valid, cmd_op);
        end
        gravity_tick = 1'b1; tick(); gravity_tick = 1'b0; tick();
        gravity_tick = 1'b1; tick(); gravity_tick = 1'b0;
        cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
        tick();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 3'd4) begin
            errors++;
            $display("FAIL grav_coalesce got valid=%b op=%0d want 1/4", cmd_valid, cmd_op);
        end
        cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
        tick(); tick();
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL grav_once got valid=%b want 0", cmd_valid);
        end
    endtask

    task automatic test_flush();
        send(8'h1C); send(8'h23); send(8'h1B); send(8'h1D);
        checks++;
        if (cmd_valid !== 1'b1 || fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL flush_setup got valid=%b cnt=%0d want 1/3", cmd_valid, fifo_count);
        end
        game_active = 1'b0;
        tick();
        checks++;
        if (cmd_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL flush got valid=%b cnt=%0d ovf=%b want 0/0/0", cmd_valid, fifo_count, overflow);
        end
        send(8'hE0);
        game_active = 1'b1;
        send(8'h74);
        checks++;
        if (fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL ext_inactive got cnt=%0d want 1", fifo_count);
        end
        tick();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 3'd1) begin
            errors++;
            $display("FAIL ext_inactive_op got valid=%b op=%0d want 1/1", cmd_valid, cmd_op);
        end
        cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    endtask

    task automatic test_async_reset();
        send(8'h1D);
        tick();
        #3;
        Resetn = 1'b0;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || cmd_op !== 3'd0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL async_reset got valid=%b op=%0d cnt=%0d want 0/0/0", cmd_valid, cmd_op, fifo_count);
        end
        tick();
        Resetn = 1'b1;
        send(8'h1C);
        tick();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 3'd0) begin
            errors++;
            $display("FAIL post_reset got valid=%b op=%0d want 1/0", cmd_valid, cmd_op);
        end
        cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    endtask

    // Reference lookup of mapped make codes; -1 means no command.
    function automatic int key_code(input logic [7:0] b, input bit ext);
        if (ext) begin
            case (b)
                8'h6B: return 0;
                8'h74: return 1;
                8'h72: return 2;
                8'h75: return 3;
                default: return -1;
            endcase
        end
        case (b)
            8'h1C: return 0;
            8'h23: return 1;
            8'h1B: return 2;
            8'h1D: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic test_random();
        int   keys[$];
        bit   m_brk = 0, m_ext = 0, m_gpend = 0, m_issue = 0, m_ovf = 0;
        int   m_op = 0;
        logic [7:0] pool [10];
        pool = '{8'h1C, 8'h23, 8'h1B, 8'h1D, 8'h6B, 8'h74, 8'h72, 8'h75, 8'hF0, 8'hE0};
        Resetn = 1'b0; #2; Resetn = 1'b1;
        game_active = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit sv, ga, gt, ack, push, tg, tk;
            logic [7:0] sd;
            int kc;
            sv  = ($urandom_range(2) == 0);
            sd  = ($urandom_range(5) == 0) ? 8'($urandom) : pool[$urandom_range(9)];
            ga  = ($urandom_range(39) != 0);
            gt  = ($urandom_range(14) == 0);
            ack = ($urandom_range(2) == 0);
            scan_valid = sv; scan_data = sd; game_active = ga; gravity_tick = gt; cmd_ack = ack;
            kc   = key_code(sd, m_ext);
            push = sv && !m_brk && (kc >= 0) && ga;
            if (!ga) begin
                keys.delete();
                m_gpend = 0; m_ovf = 0; m_issue = 0;
            end else begin
                tg = !m_issue && m_gpend;
                tk = !m_issue && !m_gpend && (keys.size() > 0);
                if (m_issue && ack) m_issue = 0;
                if (tg) begin m_issue = 1; m_op = 4; end
                if (tk) begin m_issue = 1; m_op = keys.pop_front(); end
                if (push) begin
                    if (keys.size() < DEPTH) keys.push_back(kc);
                    else m_ovf = 1;
                end
                if (gt) m_gpend = 1;
                else if (tg) m_gpend = 0;
            end
            if (sv) begin
                if (m_brk) begin m_brk = 0; m_ext = 0; end
                else if (sd == 8'hF0) m_brk = 1;
                else if (sd == 8'hE0) m_ext = 1;
                else m_ext = 0;
            end
            tick();
            checks++;
            if (cmd_valid !== m_issue || fifo_count !== 3'(keys.size()) || overflow !== m_ovf
                || (m_issue && cmd_op !== 3'(m_op))) begin
                errors++;
                $display("FAIL random cyc=%0d got valid=%b op=%0d cnt=%0d ovf=%b want %b/%0d/%0d/%b",
                         cyc, cmd_valid, cmd_op, fifo_count, overflow, m_issue, m_op, keys.size(), m_ovf);
            end
        end
        scan_valid = 1'b0; gravity_tick = 1'b0; cmd_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_break_ext();
        test_overflow();
        test_gravity();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, is the number of buffered keyboard move commands; it SHALL be a power of two, at least 2.
REQ-002 Port CLOCK_50  input  1  is the single clock; all state SHALL be updated on its rising edge.
REQ-003 Port Resetn  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-004 Port scan_data  input  8  is the PS/2 byte received from the keyboard controller.
REQ-005 Port scan_valid  input  1  is a one-cycle strobe qualifying scan_data.
REQ-006 Port game_active  input  1  is high while the screen FSM is in the gameplay mode.
REQ-007 Port gravity_tick  input  1  is a one-cycle drop strobe from the selected difficulty counter.
REQ-008 Port cmd_ack  input  1  means the board datapath has consumed the presented command.
REQ-009 Port cmd_valid  output  1  means a move command is presented.
REQ-010 Port cmd_op  output  3  is the command code: LEFT=0, RIGHT=1, DOWN=2, ROTATE=3, GRAVITY=4.
REQ-011 Port fifo_count  output  $clog2(FIFO_DEPTH)+1  is the number of buffered key commands.
REQ-012 Port overflow  output  1  is a sticky flag meaning a key command was dropped.

Function
REQ-013 Scan decoder: byte F0 SHALL set break_pend, and the next byte SHALL be consumed and discarded, clearing break_pend and ext_pend.
REQ-014 Byte E0 SHALL set ext_pend; the following non-F0 byte SHALL be decoded as extended and SHALL clear ext_pend.
REQ-015 Non-extended make codes 1C/23/1B/1D SHALL map to LEFT/RIGHT/DOWN/ROTATE (A/D/S/W); extended make codes 6B/74/72/75 SHALL map to LEFT/RIGHT/DOWN/ROTATE (arrow keys).
REQ-016 The decoder SHALL discard every other byte without pushing; E0 F0 xx SHALL push nothing; repeated make codes (typematic) SHALL each push once.
REQ-017 A decoded make code SHALL be pushed into the FIFO only while game_active=1; a push in cycle N SHALL be visible in fifo_count after edge N.
REQ-018 When the FIFO is full and no pop occurs in the same cycle, a push SHALL be dropped and overflow SHALL be set; a simultaneous pop and push when full SHALL accept the push.
REQ-019 gravity_tick while game_active=1 SHALL set grav_pend; further ticks while grav_pend=1 SHALL coalesce into it.
REQ-020 The arbiter FSM SHALL have two states: IDLE (cmd_valid=0) and ISSUE (cmd_valid=1).
REQ-021 In IDLE with grav_pend=1, the FSM SHALL load GRAVITY, clear grav_pend and enter ISSUE; gravity SHALL have priority over the FIFO.
REQ-022 Otherwise, in IDLE with the FIFO non-empty, the FSM SHALL pop the head into cmd_op and enter ISSUE.
REQ-023 In ISSUE, cmd_op SHALL be held stable until cmd_ack=1; the FSM SHALL then return to IDLE, so cmd_valid is low for at least one cycle between commands.
REQ-024 Latency: a strobe (make byte or gravity_tick) in cycle N, with the FSM in IDLE and nothing else pending, SHALL give cmd_valid=1 in cycle N+2.
REQ-025 When game_active=0, the scheduler SHALL flush the FIFO, clear grav_pend and overflow, and force IDLE at the next edge, aborting any ISSUE in progress.
REQ-026 While game_active=0, the decoder SHALL still track break_pend and ext_pend.
REQ-027 cmd_ack received while in IDLE SHALL be ignored.

Reset
REQ-028 Resetn=0 SHALL immediately force the FSM to IDLE, cmd_valid=0, cmd_op=0, fifo_count=0, overflow=0, and clear grav_pend, break_pend and ext_pend, and the FIFO pointers.

Structure
REQ-029 Package tetris_pkg SHALL hold the cmd_op encodings, the scan-code constants (F0, E0, and the eight mapped make codes) and the FIFO_DEPTH default.
REQ-030 A single sub-module, move_fifo (synchronous FIFO, parameter DEPTH, 3-bit data, push/pop/count), SHALL be instantiated once.

Verification
REQ-031 game_active=1, scan 1C -> cmd_valid=1, cmd_op=0 two cycles later; ack -> cmd_valid=0 next cycle.
REQ-032 Scans E0 75, then E0 F0 75, then F0 1D -> exactly one ROTATE (3) issued, fifo_count returns to 0.
REQ-033 With FIFO_DEPTH=4 and cmd_ack held 0, six scans of 23 -> one RIGHT issued, fifo_count=4, overflow=1.
REQ-034 gravity_tick and scan 1B in the same cycle from IDLE -> GRAVITY (4) issued first, then DOWN (2) after ack and one idle cycle; two further ticks during ISSUE -> one GRAVITY only.
REQ-035 FIFO holding 3 entries with ISSUE active, then game_active drops -> next cycle cmd_valid=0, fifo_count=0, overflow=0.
REQ-036 Resetn=0 asserted mid-ISSUE, asynchronously to the clock -> cmd_valid=0 immediately; after release, scan 1C issues LEFT normally.
